// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Recovers the hex value shown on a multiplexed 4-digit, 7-segment display
//   by snooping its digit-enable and segment lines. Every pin is synchronized.
//   A digit is captured once its enable/segment pattern has held steady for
//   SETTLE consecutive synchronized samples. A frame completes when all four
//   digits have been captured with legal patterns.
//
// Ports
//   CLK, RST_N        clock (rising edge), asynchronous active-low reset
//   DS_EN1..DS_EN4    digit enables, active-low, EN1 = most significant digit
//   DS_A..DS_G, DS_DP segment lines, active-high
//   DIGITS[15:0]      decoded digits, [15:12] from EN1 ... [3:0] from EN4
//   DP[3:0]           captured decimal points, bit 3 from EN1
//   VALID             sticky, set when the first frame completes
//   FRAME_DONE        one-cycle pulse per completed frame
//   ERR[3:0]          sticky illegal-pattern flags, bit mapping as DP

module seg_scan_decoder #(
  parameter int unsigned SETTLE = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        DS_EN1,
  input  logic        DS_EN2,
  input  logic        DS_EN3,
  input  logic        DS_EN4,
  input  logic        DS_A,
  input  logic        DS_B,
  input  logic        DS_C,
  input  logic        DS_D,
  input  logic        DS_E,
  input  logic        DS_F,
  input  logic        DS_G,
  input  logic        DS_DP,
  output logic [15:0] DIGITS,
  output logic [3:0]  DP,
  output logic        VALID,
  output logic        FRAME_DONE,
  output logic [3:0]  ERR
);

  localparam logic [7:0] CNT_MAX = 8'(SETTLE);
  // Capture fires on the edge where the count moves to SETTLE-1.
  localparam logic [7:0] CNT_CAP = 8'(SETTLE - 2);

  // {EN1, EN2, EN3, EN4, A, B, C, D, E, F, G, DP}
  logic [11:0] pins;
  logic [11:0] sync1;
  logic [11:0] sync2;
  logic [11:0] prev;

  logic [7:0]  cnt;
  logic [3:0]  seen;
  logic [3:0]  seen_nxt;

  logic [3:0]  en_n;
  logic [3:0]  sel_mask;
  logic [6:0]  seg7;
  logic        dp_in;
  logic        selected;
  logic        same;
  logic        cap;

  logic        legal;
  logic [3:0]  nib;
  logic [15:0] digits_nxt;
  logic [3:0]  dp_nxt;

  assign pins = {DS_EN1, DS_EN2, DS_EN3, DS_EN4,
                 DS_A, DS_B, DS_C, DS_D, DS_E, DS_F, DS_G, DS_DP};

  assign en_n     = sync2[11:8];
  assign seg7     = sync2[7:1];
  assign dp_in    = sync2[0];
  assign sel_mask = ~en_n;

  // Exactly one enable low: non-zero mask with a single bit set.
  assign selected = (sel_mask != 4'd0) && ((sel_mask & (sel_mask - 4'd1)) == 4'd0);
  assign same     = (sync2 == prev);
  // The count saturates past CNT_CAP, so a held pattern captures only once.
  assign cap      = selected && same && (cnt == CNT_CAP);

  // Segment pattern A..G (A = MSB) to hex value.
  always_comb begin
    legal = 1'b1;
    nib   = 4'h0;
    case (seg7)
      7'b1111110: nib = 4'h0;
      7'b0110000: nib = 4'h1;
      7'b1101101: nib = 4'h2;
      7'b1111001: nib = 4'h3;
      7'b0110011: nib = 4'h4;
      7'b1011011: nib = 4'h5;
      7'b1011111: nib = 4'h6;
      7'b1110000: nib = 4'h7;
      7'b1111111: nib = 4'h8;
      7'b1111011: nib = 4'h9;
      7'b1110111: nib = 4'hA;
      7'b0011111: nib = 4'hB;
      7'b1001110: nib = 4'hC;
      7'b0111101: nib = 4'hD;
      7'b1001111: nib = 4'hE;
      7'b1000111: nib = 4'hF;
      default:    legal = 1'b0;
    endcase
  end

  // Replace the nibble/DP bit of the selected digit.
  always_comb begin
    digits_nxt = DIGITS;
    dp_nxt     = DP;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sel_mask[i]) begin
        digits_nxt[i*4 +: 4] = nib;
        dp_nxt[i]            = dp_in;
      end
    end
  end

  // A completed frame clears the seen set in the cycle FRAME_DONE is raised.
  always_comb begin
    seen_nxt = (seen == 4'hF) ? 4'h0 : seen;
    if (cap && legal) begin
      seen_nxt = seen_nxt | sel_mask;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= pins;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (!selected || !same) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DIGITS     <= '0;
      DP         <= '0;
      VALID      <= 1'b0;
      FRAME_DONE <= 1'b0;
      ERR        <= '0;
      seen       <= '0;
    end else begin
      FRAME_DONE <= (seen == 4'hF);
      if (seen == 4'hF) begin
        VALID <= 1'b1;
      end
      seen <= seen_nxt;
      if (cap) begin
        if (legal) begin
          DIGITS <= digits_nxt;
          DP     <= dp_nxt;
        end else begin
          ERR <= ERR | sel_mask;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;

  localparam int unsigned SETTLE = 4;

  localparam logic [6:0] P1  = 7'b0110000;
  localparam logic [6:0] P2  = 7'b1101101;
  localparam logic [6:0] P3  = 7'b1111001;
  localparam logic [6:0] P4  = 7'b0110011;
  localparam logic [6:0] P5  = 7'b1011011;
  localparam logic [6:0] P6  = 7'b1011111;
  localparam logic [6:0] P7  = 7'b1110000;
  localparam logic [6:0] P8  = 7'b1111111;
  localparam logic [6:0] P9  = 7'b1111011;
  localparam logic [6:0] PA  = 7'b1110111;
  localparam logic [6:0] PB  = 7'b0011111;
  localparam logic [6:0] PC  = 7'b1001110;
  localparam logic [6:0] PD  = 7'b0111101;
  localparam logic [6:0] ILL = 7'b1010101;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        DS_EN1 = 1'b1, DS_EN2 = 1'b1, DS_EN3 = 1'b1, DS_EN4 = 1'b1;
  logic        DS_A = 1'b0, DS_B = 1'b0, DS_C = 1'b0, DS_D = 1'b0;
  logic        DS_E = 1'b0, DS_F = 1'b0, DS_G = 1'b0, DS_DP = 1'b0;
  logic [15:0] DIGITS;
  logic [3:0]  DP;
  logic        VALID;
  logic        FRAME_DONE;
  logic [3:0]  ERR;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  err;
  } frame_t;

  typedef struct packed {
    logic [15:0] digits_before;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  err;
    logic        valid;
  } obs_t;

  frame_t      exp_q[$];
  obs_t        obs_q[$];
  int          compared = 0;
  int          mismatched = 0;
  logic [15:0] last_digits = '0;

  seg_scan_decoder #(.SETTLE(SETTLE)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .DS_EN1     (DS_EN1),
    .DS_EN2     (DS_EN2),
    .DS_EN3     (DS_EN3),
    .DS_EN4     (DS_EN4),
    .DS_A       (DS_A),
    .DS_B       (DS_B),
    .DS_C       (DS_C),
    .DS_D       (DS_D),
    .DS_E       (DS_E),
    .DS_F       (DS_F),
    .DS_G       (DS_G),
    .DS_DP      (DS_DP),
    .DIGITS     (DIGITS),
    .DP         (DP),
    .VALID      (VALID),
    .FRAME_DONE (FRAME_DONE),
    .ERR        (ERR)
  );

  always #5 CLK = ~CLK;

  // Frame monitor: records the output state at every FRAME_DONE pulse,
  // together with DIGITS from the preceding cycle.
  always @(negedge CLK) begin
    if (FRAME_DONE) begin
      obs_q.push_back(obs_t'{last_digits, DIGITS, DP, ERR, VALID});
    end
    last_digits = DIGITS;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_pins(input logic [3:0] en_n, input logic [6:0] seg, input logic dp);
    {DS_EN1, DS_EN2, DS_EN3, DS_EN4} = en_n;
    {DS_A, DS_B, DS_C, DS_D, DS_E, DS_F, DS_G} = seg;
    DS_DP = dp;
  endtask

  // idx 0..3 selects EN1..EN4
  task automatic digit(input int idx, input logic [6:0] seg, input logic dp, input int n);
    logic [3:0] m;
    m = 4'b1000 >> idx;
    set_pins(~m, seg, dp);
    tick(n);
  endtask

  task automatic idle(input int n);
    set_pins(4'hF, 7'h0, 1'b0);
    tick(n);
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    idle(3);
    compared++; if (DIGITS !== 16'h0) begin mismatched++; $display("FAIL reset_digits: got %h want 0000", DIGITS); end
    compared++; if (DP !== 4'h0) begin mismatched++; $display("FAIL reset_dp: got %b want 0000", DP); end
    compared++; if (VALID !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", VALID); end
    compared++; if (FRAME_DONE !== 1'b0) begin mismatched++; $display("FAIL reset_frame_done: got %b want 0", FRAME_DONE); end
    compared++; if (ERR !== 4'h0) begin mismatched++; $display("FAIL reset_err: got %b want 0000", ERR); end
    RST_N = 1'b1;
    idle(4);
  endtask

  task automatic test_scan;
    frame_t e;
    obs_t   o;
    // Latency: EN1 pattern from idle must land on exactly the (2+SETTLE)th edge.
    set_pins(4'b0111, P2, 1'b0);
    tick(2 + SETTLE - 1);
    compared++; if (DIGITS !== 16'h0000) begin mismatched++; $display("FAIL scan_latency_early: got %h want 0000", DIGITS); end
    tick(1);
    compared++; if (DIGITS !== 16'h2000) begin mismatched++; $display("FAIL scan_latency_edge: got %h want 2000", DIGITS); end
    tick(10 - (2 + SETTLE));
    digit(1, P3, 1'b0, 10);
    digit(2, P4, 1'b0, 10);
    exp_q.push_back(frame_t'{16'h2345, 4'h0, 4'h0});
    digit(3, P5, 1'b0, 10);
    idle(5);
    compared++; if (obs_q.size() != exp_q.size()) begin mismatched++; $display("FAIL scan_frame_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      compared++;
      if (o.digits !== e.digits || o.digits_before !== e.digits || o.dp !== e.dp || o.err !== e.err || o.valid !== 1'b1) begin
        mismatched++;
        $display("FAIL scan_frame: got digits=%h prev=%h dp=%b err=%b valid=%b want digits=%h dp=%b err=%b valid=1",
                 o.digits, o.digits_before, o.dp, o.err, o.valid, e.digits, e.dp, e.err);
      end
    end
    exp_q.delete(); obs_q.delete();
    compared++; if (VALID !== 1'b1) begin mismatched++; $display("FAIL scan_valid: got %b want 1", VALID); end
    compared++; if (ERR !== 4'h0) begin mismatched++; $display("FAIL scan_err: got %b want 0000", ERR); end
    compared++; if (DIGITS !== 16'h2345) begin mismatched++; $display("FAIL scan_digits: got %h want 2345", DIGITS); end
  endtask

  task automatic test_glitch;
    digit(1, P8, 1'b0, SETTLE - 1);
    digit(1, P1, 1'b0, SETTLE - 1);
    idle(10);
    compared++; if (DIGITS !== 16'h2345) begin mismatched++; $display("FAIL glitch_digits: got %h want 2345", DIGITS); end
    compared++; if (obs_q.size() != 0) begin mismatched++; $display("FAIL glitch_frames: got %0d want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_illegal;
    frame_t e;
    obs_t   o;
    digit(2, ILL, 1'b0, 10);
    idle(5);
    compared++; if (ERR !== 4'b0010) begin mismatched++; $display("FAIL illegal_err: got %b want 0010", ERR); end
    compared++; if (DIGITS !== 16'h2345) begin mismatched++; $display("FAIL illegal_digits: got %h want 2345", DIGITS); end
    compared++; if (DP !== 4'h0) begin mismatched++; $display("FAIL illegal_dp: got %b want 0000", DP); end
    // The illegal capture must not have marked EN3 as seen.
    digit(0, P2, 1'b0, 10);
    digit(1, P3, 1'b0, 10);
    digit(3, P5, 1'b0, 10);
    idle(5);
    compared++; if (obs_q.size() != 0) begin mismatched++; $display("FAIL illegal_no_frame: got %0d want 0", obs_q.size()); end
    obs_q.delete();
    exp_q.push_back(frame_t'{16'h2345, 4'h0, 4'b0010});
    digit(2, P4, 1'b0, 10);
    idle(5);
    compared++; if (obs_q.size() != exp_q.size()) begin mismatched++; $display("FAIL illegal_frame_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      compared++;
      if (o.digits !== e.digits || o.digits_before !== e.digits || o.dp !== e.dp || o.err !== e.err || o.valid !== 1'b1) begin
        mismatched++;
        $display("FAIL illegal_frame: got digits=%h prev=%h dp=%b err=%b valid=%b want digits=%h dp=%b err=%b valid=1",
                 o.digits, o.digits_before, o.dp, o.err, o.valid, e.digits, e.dp, e.err);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_recapture;
    frame_t e;
    obs_t   o;
    digit(0, P7, 1'b0, 10);
    digit(0, P9, 1'b0, 10);
    digit(1, P8, 1'b0, 10);
    digit(2, P7, 1'b0, 10);
    idle(5);
    compared++; if (obs_q.size() != 0) begin mismatched++; $display("FAIL recapture_no_frame: got %0d want 0", obs_q.size()); end
    compared++; if (DIGITS !== 16'h9875) begin mismatched++; $display("FAIL recapture_digits: got %h want 9875", DIGITS); end
    obs_q.delete();
    exp_q.push_back(frame_t'{16'h9876, 4'h0, 4'b0010});
    digit(3, P6, 1'b0, 10);
    idle(5);
    compared++; if (obs_q.size() != exp_q.size()) begin mismatched++; $display("FAIL recapture_frame_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      compared++;
      if (o.digits !== e.digits || o.digits_before !== e.digits || o.dp !== e.dp || o.err !== e.err || o.valid !== 1'b1) begin
        mismatched++;
        $display("FAIL recapture_frame: got digits=%h prev=%h dp=%b err=%b valid=%b want digits=%h dp=%b err=%b valid=1",
                 o.digits, o.digits_before, o.dp, o.err, o.valid, e.digits, e.dp, e.err);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_overlap;
    set_pins(4'b0110, ILL, 1'b1);
    tick(20);
    idle(5);
    compared++; if (ERR !== 4'b0010) begin mismatched++; $display("FAIL overlap_err: got %b want 0010", ERR); end
    compared++; if (DIGITS !== 16'h9876) begin mismatched++; $display("FAIL overlap_digits: got %h want 9876", DIGITS); end
    compared++; if (DP !== 4'h0) begin mismatched++; $display("FAIL overlap_dp: got %b want 0000", DP); end
    compared++; if (obs_q.size() != 0) begin mismatched++; $display("FAIL overlap_frames: got %0d want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_back_to_back;
    frame_t e;
    obs_t   o;
    digit(0, P2, 1'b0, 10);
    digit(1, P3, 1'b0, 10);
    digit(2, P4, 1'b0, 10);
    exp_q.push_back(frame_t'{16'h2345, 4'h0, 4'b0010});
    digit(3, P5, 1'b0, 10);
    digit(0, PA, 1'b0, 10);
    digit(1, PB, 1'b0, 10);
    digit(2, PC, 1'b0, 10);
    exp_q.push_back(frame_t'{16'hABCD, 4'b0001, 4'b0010});
    digit(3, PD, 1'b1, 10);
    idle(5);
    compared++; if (obs_q.size() != exp_q.size()) begin mismatched++; $display("FAIL b2b_frame_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      compared++;
      if (o.digits !== e.digits || o.digits_before !== e.digits || o.dp !== e.dp || o.err !== e.err || o.valid !== 1'b1) begin
        mismatched++;
        $display("FAIL b2b_frame: got digits=%h prev=%h dp=%b err=%b valid=%b want digits=%h dp=%b err=%b valid=1",
                 o.digits, o.digits_before, o.dp, o.err, o.valid, e.digits, e.dp, e.err);
      end
    end
    exp_q.delete(); obs_q.delete();
    compared++; if (DIGITS !== 16'hABCD) begin mismatched++; $display("FAIL b2b_digits: got %h want abcd", DIGITS); end
    compared++; if (DP !== 4'b0001) begin mismatched++; $display("FAIL b2b_dp: got %b want 0001", DP); end
  endtask

  task automatic test_reset_mid;
    frame_t e;
    obs_t   o;
    digit(0, P1, 1'b0, 10);
    digit(1, P2, 1'b0, 10);
    set_pins(4'b1101, P3, 1'b0);
    tick(4);
    compared++; if (DIGITS !== 16'h12CD) begin mismatched++; $display("FAIL rstmid_pre_digits: got %h want 12cd", DIGITS); end
    #3;
    RST_N = 1'b0;
    #1;
    compared++; if (DIGITS !== 16'h0) begin mismatched++; $display("FAIL rstmid_digits: got %h want 0000", DIGITS); end
    compared++; if (DP !== 4'h0) begin mismatched++; $display("FAIL rstmid_dp: got %b want 0000", DP); end
    compared++; if (VALID !== 1'b0) begin mismatched++; $display("FAIL rstmid_valid: got %b want 0", VALID); end
    compared++; if (FRAME_DONE !== 1'b0) begin mismatched++; $display("FAIL rstmid_frame_done: got %b want 0", FRAME_DONE); end
    compared++; if (ERR !== 4'h0) begin mismatched++; $display("FAIL rstmid_err: got %b want 0000", ERR); end
    tick(3);
    RST_N = 1'b1;
    // Pins still hold EN3/'3': first capture no earlier than 2+SETTLE edges.
    tick(2 + SETTLE - 1);
    compared++; if (DIGITS !== 16'h0000) begin mismatched++; $display("FAIL rstmid_latency_early: got %h want 0000", DIGITS); end
    tick(1);
    compared++; if (DIGITS !== 16'h0030) begin mismatched++; $display("FAIL rstmid_latency_edge: got %h want 0030", DIGITS); end
    tick(4);
    digit(0, P9, 1'b0, 10);
    digit(1, P8, 1'b0, 10);
    digit(2, P7, 1'b0, 10);
    exp_q.push_back(frame_t'{16'h9876, 4'h0, 4'h0});
    digit(3, P6, 1'b0, 10);
    idle(5);
    compared++; if (obs_q.size() != exp_q.size()) begin mismatched++; $display("FAIL rstmid_frame_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      compared++;
      if (o.digits !== e.digits || o.digits_before !== e.digits || o.dp !== e.dp || o.err !== e.err || o.valid !== 1'b1) begin
        mismatched++;
        $display("FAIL rstmid_frame: got digits=%h prev=%h dp=%b err=%b valid=%b want digits=%h dp=%b err=%b valid=1",
                 o.digits, o.digits_before, o.dp, o.err, o.valid, e.digits, e.dp, e.err);
      end
    end
    exp_q.delete(); obs_q.delete();
    compared++; if (VALID !== 1'b1) begin mismatched++; $display("FAIL rstmid_valid_after: got %b want 1", VALID); end
    compared++; if (ERR !== 4'h0) begin mismatched++; $display("FAIL rstmid_err_after: got %b want 0000", ERR); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_glitch();
    test_illegal();
    test_recapture();
    test_overlap();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 The module SHALL have parameter SETTLE, default 4, range 2..255: the number of consecutive identical synchronized samples required before capture.
REQ-002 Port CLK, input, 1 bit: the single clock; all state SHALL be updated on the rising edge.
REQ-003 Port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Ports DS_EN1, DS_EN2, DS_EN3, DS_EN4, inputs, 1 bit each: digit enables, active-low; DS_EN1 selects the most significant digit.
REQ-005 Ports DS_A, DS_B, DS_C, DS_D, DS_E, DS_F, DS_G, DS_DP, inputs, 1 bit each: segment lines, active-high.
REQ-006 Port DIGITS, output, 16 bits: the decoded hex digits; [15:12] comes from EN1 and [3:0] from EN4.
REQ-007 Port DP, output, 4 bits: the captured decimal points; bit 3 comes from EN1.
REQ-008 Port VALID, output, 1 bit: high once a complete frame has been captured.
REQ-009 Port FRAME_DONE, output, 1 bit: a one-cycle pulse per completed frame.
REQ-010 Port ERR, output, 4 bits: sticky flags marking an illegal segment pattern per digit; bit mapping as DP.

Function
REQ-011 All 12 inputs SHALL pass through 2-flop synchronizers; all further logic uses only synchronized values.
REQ-012 A sample SHALL be "selected" only when exactly one synchronized enable is low.
REQ-013 The stability counter SHALL increment, saturating at SETTLE, while the sample is selected and the {enables, segments} are equal to the previous cycle's values.
REQ-014 The stability counter SHALL be cleared to 0 on any change in {enables, segments}, and on any non-selected sample (zero or more than one enable low).
REQ-015 Capture SHALL occur on the edge at which the counter reaches SETTLE-1, i.e. after SETTLE identical samples.
REQ-016 At most one capture SHALL occur per stable interval; a new capture requires the counter to be cleared first.
REQ-017 The decode table SHALL be, with the pattern written as A..G (MSB=A):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
REQ-018 On capturing a legal pattern, the selected DIGITS nibble and the DP bit SHALL be updated, and that digit's "seen" bit SHALL be set.
REQ-019 On capturing an illegal pattern, the selected ERR bit SHALL be set, DIGITS and DP SHALL be left unchanged, and the seen bit SHALL be left unchanged.
REQ-020 When all 4 seen bits are set after a capture, FRAME_DONE SHALL pulse high for the next cycle, VALID SHALL go high, and the seen bits SHALL be cleared in that same cycle.
REQ-021 DIGITS and DP SHALL update one cycle before FRAME_DONE.
REQ-022 Recapturing an already-seen digit before the frame completes SHALL overwrite that nibble and SHALL NOT count twice toward frame completion.
REQ-023 Once set, ERR bits SHALL clear only on reset; once set, VALID SHALL clear only on reset.
REQ-024 The total latency from a stable pin pattern to the DIGITS update SHALL be 2 (sync) + SETTLE cycles.
REQ-025 If more than one enable is low, no capture, no error and no state change other than clearing the counter SHALL occur.

Reset
REQ-026 While RST_N is 0, the following SHALL be 0: DIGITS, DP, VALID, FRAME_DONE, ERR, the seen bits, the counter and the synchronizers.
REQ-027 An assertion of RST_N mid-capture SHALL abort the capture, and no partial update SHALL remain.
REQ-028 After reset deasserts, the first capture SHALL occur no earlier than 2+SETTLE cycles later.

Verification
REQ-029 Scan scenario: drive EN1..EN4 in turn, each low for 10 cycles with patterns 1101101, 1111001, 0110011, 1011011 -> DIGITS=16'h2345, DP=0, one FRAME_DONE pulse, VALID=1, ERR=0.
REQ-030 Glitch scenario: with SETTLE=4, hold EN2 low with segments stable for only 3 cycles, then change them -> no capture and DIGITS unchanged.
REQ-031 Illegal-pattern scenario: hold EN3 low with 1010101 for 10 cycles -> ERR=4'b0010, DIGITS[7:4] unchanged, no FRAME_DONE from this digit.
REQ-032 Overlap scenario: hold EN1 and EN4 low together for 20 cycles -> no capture, ERR and DIGITS unchanged.
REQ-033 Repeat scenario: run two full frames, 16'h2345 then 16'hAbCd with DS_DP high on EN4 -> two FRAME_DONE pulses, final DIGITS=16'hABCD, DP=4'b0001.
REQ-034 Reset scenario: assert RST_N=0 during the third digit of a frame -> all outputs 0 immediately, and the next full scan produces exactly one FRAME_DONE.
